// File: rtl/latch_bank_ctrl_pkg.sv
// Shared definitions for the latch bank write controller: FSM state encoding,
// default phase lengths and the phase-counter sizing helper.
package latch_bank_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_OPEN  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_ACK   = 3'd4
   } ctrl_state_e;

   localparam int DEF_OPEN_CYC  = 2;
   localparam int DEF_GUARD_CYC = 1;

   // The phase counter only ever counts up to (longest phase - 1).
   function automatic int phaseCntWidth(input int guardCyc, input int openCyc);
      int longest;
      longest = (guardCyc > openCyc) ? guardCyc : openCyc;
      return (longest > 1) ? $clog2(longest) : 1;
   endfunction

endpackage

// File: rtl/latch_bank_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; owns the last_grant register, which only
// moves when the controller is ready to accept a grant.
module rr_arb2
   import latch_bank_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req0_i,
   input  logic req1_i,
   input  logic grantEn_i,
   output logic gnt0_o,
   output logic gnt1_o
);

   logic lastGrant_q;

   // On a tie the requester that was not served last wins; reset favours 0.
   always_comb begin
      gnt0_o = req0_i & (~req1_i | lastGrant_q);
      gnt1_o = req1_i & (~req0_i | ~lastGrant_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lastGrant_q <= 1'b1;
      end else if (grantEn_i && (gnt0_o || gnt1_o)) begin
         lastGrant_q <= gnt1_o;
      end
   end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write controller for a D-latch storage bank: arbitrates two four-phase
// requesters and frames each one-hot enable pulse with setup/hold guard cycles.
module latch_bank_ctrl
   import latch_bank_ctrl_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 2,
   parameter int OPEN_CYC  = DEF_OPEN_CYC,
   parameter int GUARD_CYC = DEF_GUARD_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [WIDTH-1:0]  data0,
   input  logic [WIDTH-1:0]  data1,
   output logic              ack0,
   output logic              ack1,
   output logic [WIDTH-1:0]  lat_D,
   output logic [DEPTH-1:0]  lat_En,
   output logic              busy,
   output logic              wr_err
);

   localparam int CNT_W = phaseCntWidth(GUARD_CYC, OPEN_CYC);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
   localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_CYC - 1);

   ctrl_state_e       state_q;
   logic [CNT_W-1:0]  phaseCnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              gntId_q;
   logic              err_q;
   logic              ack0_q;
   logic              ack1_q;
   logic              busy_q;
   logic              wrErr_q;
   logic [WIDTH-1:0]  latD_q;
   logic [DEPTH-1:0]  latEn_q;

   logic              gnt0;
   logic              gnt1;
   logic              grantEn;
   logic              grantedReq;
   logic [ADDR_W-1:0] addrSel_d;
   logic [WIDTH-1:0]  dataSel_d;
   logic [DEPTH-1:0]  latEn_d;
   logic              addrBad_d;

   assign grantEn    = (state_q == ST_IDLE);
   assign addrSel_d  = gnt1 ? addr1 : addr0;
   assign dataSel_d  = gnt1 ? data1 : data0;
   assign grantedReq = gntId_q ? req1 : req0;

   rr_arb2 uArb (
      .clk       (clk),
      .rst       (rst),
      .req0_i    (req0),
      .req1_i    (req1),
      .grantEn_i (grantEn),
      .gnt0_o    (gnt0),
      .gnt1_o    (gnt1)
   );

   // Addresses with no matching word decode to an all-zero enable.
   always_comb begin
      latEn_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr_q == ADDR_W'(i)) begin
            latEn_d[i] = 1'b1;
         end
      end
      addrBad_d = (latEn_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         phaseCnt_q <= '0;
         addr_q     <= '0;
         gntId_q    <= 1'b0;
         err_q      <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         busy_q     <= 1'b0;
         wrErr_q    <= 1'b0;
         latD_q     <= '0;
         latEn_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt0 || gnt1) begin
                  gntId_q    <= gnt1;
                  addr_q     <= addrSel_d;
                  latD_q     <= dataSel_d;
                  phaseCnt_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (phaseCnt_q == GUARD_LAST) begin
                  phaseCnt_q <= '0;
                  latEn_q    <= latEn_d;
                  err_q      <= addrBad_d;
                  state_q    <= ST_OPEN;
               end else begin
                  phaseCnt_q <= phaseCnt_q + CNT_W'(1);
               end
            end
            ST_OPEN: begin
               if (phaseCnt_q == OPEN_LAST) begin
                  phaseCnt_q <= '0;
                  latEn_q    <= '0;
                  state_q    <= ST_HOLD;
               end else begin
                  phaseCnt_q <= phaseCnt_q + CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (phaseCnt_q == GUARD_LAST) begin
                  phaseCnt_q <= '0;
                  ack0_q     <= ~gntId_q;
                  ack1_q     <= gntId_q;
                  wrErr_q    <= err_q;
                  state_q    <= ST_ACK;
               end else begin
                  phaseCnt_q <= phaseCnt_q + CNT_W'(1);
               end
            end
            ST_ACK: begin
               if (!grantedReq) begin
                  ack0_q  <= 1'b0;
                  ack1_q  <= 1'b0;
                  wrErr_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               phaseCnt_q <= '0;
               ack0_q     <= 1'b0;
               ack1_q     <= 1'b0;
               wrErr_q    <= 1'b0;
               latEn_q    <= '0;
               busy_q     <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign lat_D  = latD_q;
   assign lat_En = latEn_q;
   assign busy   = busy_q;
   assign wr_err = wrErr_q;

endmodule

// File: doc/latch_bank_ctrl.md
# latch_bank_ctrl

Write controller and two-port arbiter for a gate-level D-latch storage bank (DEPTH words × WIDTH bits, one level-sensitive enable per word). It accepts write requests from two requesters over a four-phase req/ack handshake. It grants them round-robin and drives the shared data bus and one-hot latch enables. Every enable pulse is bracketed by setup and hold guard cycles, so latch D inputs are stable across the enable window despite gate delays.

## Interface
- WIDTH, 8, data width of each latch word
- DEPTH, 4, number of latch words (1..2**ADDR_W)
- ADDR_W, 2, requester address width
- OPEN_CYC, 2, cycles lat_En is held high (≥1)
- GUARD_CYC, 1, setup cycles before and hold cycles after the enable window (≥1)

- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- req0 / req1  input  1  write request, requester 0 / 1
- addr0 / addr1  input  ADDR_W  target word; stable while req high
- data0 / data1  input  WIDTH  write data; stable while req high
- ack0 / ack1  output  1  write complete; held until matching req drops
- lat_D  output  WIDTH  shared data to all latch D inputs
- lat_En  output  DEPTH  one-hot latch enables
- busy  output  1  high in any state other than IDLE
- wr_err  output  1  high with ack when granted addr ≥ DEPTH

## Operation
- All outputs are registered. Reset values: ack0=ack1=0, lat_D=0, lat_En=0, busy=0, wr_err=0, state=IDLE, last_grant=1.
- FSM states: IDLE, SETUP, OPEN, HOLD, ACK.
- IDLE: if any req is high, grant one, latch its addr/data into internal registers, load lat_D, go to SETUP. Otherwise stay.
- Arbitration: single request → grant it. Both requests → grant the requester ≠ last_grant, then update last_grant. After reset, requester 0 wins the first tie.
- SETUP: GUARD_CYC cycles. lat_D driven, lat_En=0. Then OPEN.
- OPEN: OPEN_CYC cycles. lat_En[addr]=1, all other bits 0. If addr ≥ DEPTH, lat_En stays 0 and an error flag is set. Then HOLD.
- HOLD: GUARD_CYC cycles. lat_En=0, lat_D unchanged. Then ACK.
- ACK: ack of the granted requester=1, and wr_err=error flag. Stay until that requester's req=0. Then drop ack and wr_err and go to IDLE.
- lat_D changes only on entry to SETUP. It holds its last value in IDLE.
- The ungranted requester waits with req held. It is served in the next IDLE cycle.
- A req that drops before grant is simply not served. A req that drops mid-transaction does not abort it; ack still asserts.
- Asynchronous rst at any point forces reset values immediately, including lat_En=0. The contents of a word whose enable was cut short are unspecified.

## Timing
- Let edge k be the rising edge at which IDLE samples the req.
- lat_D valid from edge k.
- lat_En high from edge k+GUARD_CYC through edge k+GUARD_CYC+OPEN_CYC (exactly OPEN_CYC cycles).
- ack rises at edge k+2·GUARD_CYC+OPEN_CYC. With defaults this is k+4.
- ack falls on the first edge at which the granted req is sampled low. IDLE follows on that same edge.
- Next grant at the earliest is the edge after that. Minimum transaction period is 2·GUARD_CYC+OPEN_CYC+2 cycles (6 with defaults).
- lat_En is never high in two words at once and is never high in the same cycle lat_D changes.

## Structure
- Shared include file latch_ctrl_defs.vh holds:
  - state encodings (IDLE=0, SETUP=1, OPEN=2, HOLD=3, ACK=4; 3 bits)
  - guard/open default constants
- One sub-module, rr_arb2: two-input round-robin arbiter holding the last_grant register, with a grant-enable input pulsed in IDLE.
- Phase counter width is sized to the larger of GUARD_CYC and OPEN_CYC.

## Test plan
- Reset: assert rst mid-OPEN with lat_En=4'b0100 → lat_En=0, ack=0, busy=0 without waiting for a clock edge. After release, the first tie is granted to req0.
- Single write: req0=1, addr0=2, data0=8'hA5 at edge k → lat_D=8'hA5 from k, lat_En=4'b0100 during k+1..k+3, ack0 rises at k+4. Drop req0 → ack0 falls next edge, then busy=0.
- Tie: req0 and req1 both high from reset → req0 served first, then req1. Repeat the tie → req1 is not served twice in a row; grants alternate 0,1,0,1.
- Held ack: keep req1 high for 10 cycles after ack1 → ack1 stays high, FSM stays in ACK, and req0 is not granted until req1 drops.
- Bad address: DEPTH=3, req0 with addr0=3 → lat_En stays 0 throughout, and ack0 and wr_err both assert at k+4.
- Guard check (GUARD_CYC=2, OPEN_CYC=1): any write → lat_En high exactly 1 cycle, lat_D stable from 2 cycles before through 2 cycles after, and ack at k+5.
